clk_trig_encoder: RTL and testbench

- Multi-channel, parametrised clock/trigger encoder driven from the single board fast clock.
- Each channel emits a divided clock whose duty cycle encodes a synchronised trigger bit. A gated mode suppresses the clock instead.
- Each channel also counts trigger rising events.
- Sits between the board trigger inputs and the SMA/header outputs.

---
 rtl/clk_trig_encoder_if.sv | 26 ++
 rtl/clk_trig_encoder.sv | 137 +++++++++++++
 tb/tb_clk_trig_encoder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_trig_encoder_if.sv
// Control/status bundle for clk_trig_encoder.
// master: drives enable/mode/trigger/cnt_clr and observes the outputs.
// slave : the encoder itself.
interface clk_trig_encoder_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 8
);
    logic                    enable;
    logic [1:0]              mode;
    logic [N_CH-1:0]         trigger;
    logic                    cnt_clr;
    logic [N_CH-1:0]         clk_out;
    logic [N_CH-1:0]         trig_sync;
    logic                    period_start;
    logic [N_CH*CNT_W-1:0]   evt_count;

    modport master (
        output enable, mode, trigger, cnt_clr,
        input  clk_out, trig_sync, period_start, evt_count
    );

    modport slave (
        input  enable, mode, trigger, cnt_clr,
        output clk_out, trig_sync, period_start, evt_count
    );
endinterface

// File: rtl/clk_trig_encoder.sv
// Multi-channel clock/trigger encoder.
// Each channel emits a DIV-cycle clock whose high time encodes the
// synchronised trigger bit (or gates the clock, or forces DC levels).
// Trigger and mode are sampled only at a channel's phase 0, so a period
// already in flight always completes with its original shape.
// Per-channel saturating counters count rising edges of the synced trigger.
// Optional build macro: CLK_TRIG_STAGGER_EN -- offsets channel i by
// i*(DIV/N_CH) cycles to spread output edges across the period.
module clk_trig_encoder #(
    parameter int N_CH    = 2,
    parameter int DIV     = 4,
    parameter int HI_ONE  = 1,
    parameter int HI_ZERO = 3,
    parameter int CNT_W   = 8
) (
    input  logic              fastclk,
    input  logic              reset,
    clk_trig_encoder_if.slave bus
);
    localparam int PHW = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int HLW = $clog2(DIV + 1);
`ifdef CLK_TRIG_STAGGER_EN
    localparam int STEP = DIV / N_CH;
`endif

    typedef logic [HLW-1:0] hl_t;
    localparam hl_t HL_ONE  = hl_t'(HI_ONE);
    localparam hl_t HL_ZERO = hl_t'(HI_ZERO);
    localparam hl_t HL_HALF = hl_t'(DIV / 2);
    localparam hl_t HL_DIV  = hl_t'(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("clk_trig_encoder: DIV must be at least 2");
    end
    if (HI_ONE < 1 || HI_ONE > DIV - 1) begin : g_bad_hi_one
        $error("clk_trig_encoder: HI_ONE must lie in 1..DIV-1");
    end
    if (HI_ZERO < 1 || HI_ZERO > DIV - 1) begin : g_bad_hi_zero
        $error("clk_trig_encoder: HI_ZERO must lie in 1..DIV-1");
    end
    if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
        $error("clk_trig_encoder: N_CH must lie in 1..8");
    end

    // High time of one period for a given latched mode and trigger.
    function automatic hl_t hi_len(input logic [1:0] m, input logic t);
        case (m)
            2'b00:   hi_len = t ? HL_ONE : HL_ZERO;
            2'b01:   hi_len = t ? hl_t'(0) : HL_HALF;
            2'b10:   hi_len = hl_t'(0);
            default: hi_len = HL_DIV;
        endcase
    endfunction

    logic [N_CH-1:0]            sync_m_q, sync_q, sync_prev_q;
    logic [PHW-1:0]             phase_q, phase_d;
    logic [N_CH-1:0]            trig_lat_q, trig_lat_d;
    logic [N_CH-1:0][1:0]       mode_lat_q, mode_lat_d;
    logic [N_CH-1:0]            clk_out_q, clk_out_d;
    logic                       period_start_q, period_start_d;
    logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0][HLW-1:0]   phase_ch;

    // Per-channel phase: shared phase, optionally rotated per channel.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
`ifdef CLK_TRIG_STAGGER_EN
            phase_ch[i] = HLW'((int'(phase_q) + i * STEP) % DIV);
`else
            phase_ch[i] = HLW'(phase_q);
`endif
        end
    end

    // Phase advance, period latch and next clock level; the latch value
    // is used in the same cycle so phase 0 already shows the new shape.
    always_comb begin
        phase_d        = '0;
        period_start_d = 1'b0;
        trig_lat_d     = trig_lat_q;
        mode_lat_d     = mode_lat_q;
        clk_out_d      = '0;
        if (bus.enable) begin
            phase_d        = (phase_q == PHW'(DIV - 1)) ? '0 : phase_q + 1'b1;
            period_start_d = (phase_q == '0);
            for (int i = 0; i < N_CH; i++) begin
                if (phase_ch[i] == '0) begin
                    trig_lat_d[i] = sync_q[i];
                    mode_lat_d[i] = bus.mode;
                end
                clk_out_d[i] = (phase_ch[i] < hi_len(mode_lat_d[i], trig_lat_d[i]));
            end
        end
    end

    // Saturating edge counters; clear wins over a coincident edge.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.cnt_clr) begin
                cnt_d[i] = '0;
            end else if (sync_q[i] && !sync_prev_q[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // State registers, all cleared asynchronously by reset.
    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            sync_m_q       <= '0;
            sync_q         <= '0;
            sync_prev_q    <= '0;
            phase_q        <= '0;
            trig_lat_q     <= '0;
            mode_lat_q     <= '0;
            clk_out_q      <= '0;
            period_start_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            sync_m_q       <= bus.trigger;
            sync_q         <= sync_m_q;
            sync_prev_q    <= sync_q;
            phase_q        <= phase_d;
            trig_lat_q     <= trig_lat_d;
            mode_lat_q     <= mode_lat_d;
            clk_out_q      <= clk_out_d;
            period_start_q <= period_start_d;
            cnt_q          <= cnt_d;
        end
    end

    assign bus.clk_out      = clk_out_q;
    assign bus.trig_sync    = sync_q;
    assign bus.period_start = period_start_q;
    assign bus.evt_count    = cnt_q;
endmodule

// File: tb/tb_clk_trig_encoder.sv
// Bench for clk_trig_encoder: instance A uses the default parameters,
// instance B uses DIV=8 and CNT_W=2 for gate mode and counter saturation.
module tb_clk_trig_encoder;
    logic fastclk = 1'b0;
    logic reset;

    clk_trig_encoder_if #(.N_CH(2), .CNT_W(8)) bus_a ();
    clk_trig_encoder_if #(.N_CH(2), .CNT_W(2)) bus_b ();

    clk_trig_encoder #(.N_CH(2), .DIV(4), .HI_ONE(1), .HI_ZERO(3), .CNT_W(8)) u_dut_a (
        .fastclk (fastclk),
        .reset   (reset),
        .bus     (bus_a)
    );

    clk_trig_encoder #(.N_CH(2), .DIV(8), .HI_ONE(1), .HI_ZERO(3), .CNT_W(2)) u_dut_b (
        .fastclk (fastclk),
        .reset   (reset),
        .bus     (bus_b)
    );

    always #5 fastclk = ~fastclk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [1:0] clk;
        logic       ps;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t observe(input bit sel);
        exp_t o;
        o.clk = sel ? bus_b.clk_out : bus_a.clk_out;
        o.ps  = sel ? bus_b.period_start : bus_a.period_start;
        return o;
    endfunction

    task automatic steps(input int n);
        repeat (n) @(negedge fastclk);
    endtask

    // Expected clk_out/period_start for displayed phases [from, to).
    task automatic push_pat(input int hi0, input int hi1, input int div,
                            input int from, input int to);
        for (int p = from; p < to; p++) begin
            exp_t e;
            e.clk[0] = (p < hi0);
            e.clk[1] = (p < hi1);
            e.ps     = (p == 0);
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input bit sel, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            exp_t o;
            e = sb_q.pop_front();
            o = observe(sel);
            check(tag, 32'(o), 32'(e));
            @(negedge fastclk);
        end
    endtask

    task automatic wait_ps(input bit sel, input string tag);
        exp_t o;
        int   k;
        k = 0;
        o = observe(sel);
        while (!o.ps && k < 40) begin
            @(negedge fastclk);
            k++;
            o = observe(sel);
        end
        if (k >= 40) check({tag, "_ps_timeout"}, 32'(o.ps), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        bus_a.enable  = 1'b0;
        bus_a.mode    = 2'b00;
        bus_a.trigger = 2'b00;
        bus_a.cnt_clr = 1'b0;
        bus_b.enable  = 1'b0;
        bus_b.mode    = 2'b00;
        bus_b.trigger = 2'b00;
        bus_b.cnt_clr = 1'b0;
        steps(2);

        check("rst_clk_out",   32'(bus_a.clk_out), 32'd0);
        check("rst_trig_sync", 32'(bus_a.trig_sync), 32'd0);
        check("rst_pstart",    32'(bus_a.period_start), 32'd0);
        check("rst_cnt_a",     32'(bus_a.evt_count), 32'd0);
        check("rst_cnt_b",     32'(bus_b.evt_count), 32'd0);

        // Duty encode, trigger low: 3 of 4 high.
        reset        = 1'b1;
        bus_a.enable = 1'b1;
        steps(3);
        wait_ps(0, "duty0");
        push_pat(3, 3, 4, 0, 4);
        push_pat(3, 3, 4, 0, 4);
        drain(0, 8, "duty0");

        // Trigger high: 1 of 4 high.
        bus_a.trigger = 2'b11;
        steps(3);
        wait_ps(0, "duty1");
        push_pat(1, 1, 4, 0, 4);
        push_pat(1, 1, 4, 0, 4);
        drain(0, 8, "duty1");

        // Trigger dropped while the phase counter is at 2.
        wait_ps(0, "toggle");
        push_pat(1, 1, 4, 0, 1);
        drain(0, 1, "toggle_cur");
        bus_a.trigger = 2'b00;
        push_pat(1, 1, 4, 1, 4);
        push_pat(3, 3, 4, 0, 4);
        drain(0, 7, "toggle");

        // Channels are independent.
        bus_a.trigger = 2'b01;
        steps(3);
        wait_ps(0, "mixed");
        push_pat(1, 3, 4, 0, 4);
        drain(0, 4, "mixed");

        // Force high, then force low requested mid-period.
        bus_a.mode = 2'b11;
        steps(1);
        wait_ps(0, "force");
        push_pat(4, 4, 4, 0, 1);
        drain(0, 1, "force_hi");
        bus_a.mode = 2'b10;
        push_pat(4, 4, 4, 1, 4);
        push_pat(0, 0, 4, 0, 4);
        drain(0, 7, "force");

        // Enable low holds outputs low; restart gives phase 0 next cycle.
        bus_a.mode    = 2'b00;
        bus_a.trigger = 2'b00;
        steps(3);
        bus_a.enable = 1'b0;
        steps(1);
        for (int k = 0; k < 3; k++) begin
            check("en_off", 32'(observe(0)), 32'd0);
            steps(1);
        end
        bus_a.enable = 1'b1;
        steps(1);
        push_pat(3, 3, 4, 0, 4);
        push_pat(3, 3, 4, 0, 4);
        drain(0, 8, "en_restart");

        // Gate mode on DIV=8: 4/4 clock, then solid low after trigger.
        bus_b.enable  = 1'b1;
        bus_b.mode    = 2'b01;
        bus_b.trigger = 2'b00;
        steps(3);
        wait_ps(1, "gate0");
        push_pat(4, 4, 8, 0, 8);
        push_pat(4, 4, 8, 0, 8);
        drain(1, 16, "gate0");
        push_pat(4, 4, 8, 0, 1);
        drain(1, 1, "gate_cur");
        bus_b.trigger = 2'b11;
        push_pat(4, 4, 8, 1, 8);
        push_pat(0, 0, 8, 0, 8);
        drain(1, 15, "gate1");
        bus_b.enable  = 1'b0;
        bus_b.trigger = 2'b00;

        // Event counters on A channel 1.
        bus_a.cnt_clr = 1'b1;
        steps(1);
        bus_a.cnt_clr = 1'b0;
        check("cnt_clr", 32'(bus_a.evt_count), 32'd0);

        bus_a.trigger[1] = 1'b1;
        steps(1);
        check("sync_lag1", 32'(bus_a.trig_sync[1]), 32'd0);
        steps(1);
        check("sync_lag2", 32'(bus_a.trig_sync[1]), 32'd1);
        steps(1);
        bus_a.trigger[1] = 1'b0;
        steps(3);
        check("cnt_p1", 32'(bus_a.evt_count[15:8]), 32'd1);

        bus_a.trigger[1] = 1'b1;
        steps(3);
        bus_a.trigger[1] = 1'b0;
        steps(3);
        check("cnt_p2", 32'(bus_a.evt_count[15:8]), 32'd2);

        bus_a.trigger[1] = 1'b1;
        steps(1);
        check("cnt_p3_pre1", 32'(bus_a.evt_count[15:8]), 32'd2);
        steps(1);
        check("cnt_p3_pre2", 32'(bus_a.evt_count[15:8]), 32'd2);
        bus_a.cnt_clr = 1'b1;
        steps(1);
        bus_a.cnt_clr = 1'b0;
        check("cnt_clr_edge", 32'(bus_a.evt_count[15:8]), 32'd0);
        bus_a.trigger[1] = 1'b0;
        steps(3);
        check("cnt_after_clr", 32'(bus_a.evt_count[15:8]), 32'd0);
        check("cnt_ch0_idle",  32'(bus_a.evt_count[7:0]), 32'd0);

        // Saturation on B (CNT_W=2) while B is disabled.
        bus_b.cnt_clr = 1'b1;
        steps(1);
        bus_b.cnt_clr = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus_b.trigger[0] = 1'b1;
            steps(3);
            bus_b.trigger[0] = 1'b0;
            steps(3);
            check("cnt_sat", 32'(bus_b.evt_count[1:0]), (k < 3) ? k : 3);
        end
        check("cnt_sat_ch1", 32'(bus_b.evt_count[3:2]), 32'd0);

        // Asynchronous reset in the middle of a high phase.
        bus_a.trigger[0] = 1'b1;
        steps(3);
        bus_a.trigger[0] = 1'b0;
        steps(10);
        wait_ps(0, "pre_rst");
        push_pat(3, 3, 4, 0, 2);
        drain(0, 2, "pre_rst");
        check("pre_rst_clk", 32'(bus_a.clk_out), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("arst_clk_out", 32'(bus_a.clk_out), 32'd0);
        check("arst_cnt_a",   32'(bus_a.evt_count), 32'd0);
        check("arst_cnt_b",   32'(bus_b.evt_count), 32'd0);
        @(negedge fastclk);
        reset = 1'b1;
        steps(1);
        push_pat(3, 3, 4, 0, 4);
        push_pat(3, 3, 4, 0, 4);
        drain(0, 8, "rst_restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
